// File: rtl/trap_ctrl_unit.sv
// trap_ctrl_unit
// Machine-mode trap controller that sits beside the MEM stage of a 5-stage
// RISC-V pipeline. It owns the trap CSRs, decides each cycle between
// exception / interrupt / mret / wfi, and turns that decision into a
// registered one-cycle redirect + flush pulse for the PC mux and pipeline
// registers.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   csr_rw_in, csr_wsc_mode_in    CSR access valid, 01 write / 10 set / 11 clear / 00 read
//   csr_rw_addr_in, csr_wdata_in  CSR address and already-muxed write operand
//   csr_r_data_out                combinational read of the addressed CSR (pre-edge value)
//   irq_in                        level-sensitive local interrupt lines (mip bit 16+i)
//   illegal_inst, l_access_fault,
//   s_access_fault, ecall_m       MEM-stage exceptions
//   mret, wfi, inst_valid         MEM-stage instructions / MEM holds a real instruction
//   epc_cur, epc_next             PC of the MEM instruction and of its successor
//   bad_addr, bad_inst            mtval sources
//   PC_redirect, redirect_mux     registered redirect target and one-cycle pulse
//   reg_*_flush                   registered pipeline-register flushes
//   RegWrite_cancel               combinational kill of MEM writeback on exception
//   stall_wfi                     freeze the pipeline while sleeping in WFI
//   dbg_state_out                 current FSM state (0 RUN, 1 FLUSH, 2 WAIT)
//
// Handshake: there is no valid/ready pairing here. Every MEM-stage input is a
// single-cycle qualifier sampled in the cycle it is high; the controller never
// back-pressures except through stall_wfi, and the redirect pulse is
// fire-and-forget for exactly one cycle.
module trap_ctrl_unit #(
  parameter int unsigned      XLEN      = 32,
  parameter int unsigned      NUM_IRQ   = 8,
  parameter bit               VECTORED  = 1'b1,
  parameter logic [XLEN-1:0]  MTVEC_RST = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_rw_in,
  input  logic [1:0]         csr_wsc_mode_in,
  input  logic [11:0]        csr_rw_addr_in,
  input  logic [XLEN-1:0]    csr_wdata_in,
  output logic [XLEN-1:0]    csr_r_data_out,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               illegal_inst,
  input  logic               l_access_fault,
  input  logic               s_access_fault,
  input  logic               ecall_m,
  input  logic               mret,
  input  logic               wfi,
  input  logic               inst_valid,
  input  logic [XLEN-1:0]    epc_cur,
  input  logic [XLEN-1:0]    epc_next,
  input  logic [XLEN-1:0]    bad_addr,
  input  logic [XLEN-1:0]    bad_inst,
  output logic [XLEN-1:0]    PC_redirect,
  output logic               redirect_mux,
  output logic               reg_FD_flush,
  output logic               reg_DE_flush,
  output logic               reg_EM_flush,
  output logic               reg_MW_flush,
  output logic               RegWrite_cancel,
  output logic               stall_wfi,
  output logic [1:0]         dbg_state_out
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;

  // Only the local-interrupt enables exist in mie.
  localparam logic [XLEN-1:0] MIE_MASK = XLEN'(((64'd1 << NUM_IRQ) - 64'd1) << 16);

  // State and CSR registers
  state_e             state_q, state_d;
  logic               mstatus_mie_q, mstatus_mie_d;
  logic               mstatus_mpie_q, mstatus_mpie_d;
  logic [XLEN-1:0]    mie_q, mie_d;
  logic [XLEN-1:0]    mtvec_q, mtvec_d;
  logic [XLEN-1:0]    mscratch_q, mscratch_d;
  logic [XLEN-1:2]    mepc_q, mepc_d;          // low bits are hardwired to zero
  logic [XLEN-1:0]    mcause_q, mcause_d;
  logic [XLEN-1:0]    mtval_q, mtval_d;

  // Registered outputs
  logic               redirect_q, redirect_d;
  logic [XLEN-1:0]    pc_redirect_q, pc_redirect_d;
  logic               flush_q, flush_d;        // FD/DE/EM
  logic               flush_mw_q, flush_mw_d;

  // Decision signals
  logic [XLEN-1:0]    mip_w;
  logic [XLEN-1:0]    pending;
  logic               pend_any;
  logic [4:0]         irq_code;
  logic               exc_any;
  logic [XLEN-1:0]    exc_cause;
  logic [XLEN-1:0]    exc_tval;
  logic               in_run, in_wait;
  logic               intr_ok;
  logic               take_exc, take_intr, take_trap, take_mret, go_wait, wake;
  logic               csr_commit;
  logic [XLEN-1:0]    rdata;
  logic [XLEN-1:0]    wval;
  logic [XLEN-1:0]    mtvec_base;
  logic [XLEN-1:0]    target;

  always_comb begin
    mip_w = '0;
    mip_w[16 +: NUM_IRQ] = irq_in;
  end

  assign pending  = mip_w & mie_q;
  assign pend_any = |pending;

  // Lowest pending index wins: scan from the top so the last hit is the lowest.
  always_comb begin
    irq_code = 5'd16;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (pending[16 + i]) irq_code = 5'(16 + i);
    end
  end

  assign exc_any = illegal_inst | l_access_fault | s_access_fault | ecall_m;

  always_comb begin
    if (illegal_inst)        exc_cause = XLEN'(2);
    else if (l_access_fault) exc_cause = XLEN'(5);
    else if (s_access_fault) exc_cause = XLEN'(7);
    else                     exc_cause = XLEN'(11);
  end

  always_comb begin
    if (illegal_inst)                          exc_tval = bad_inst;
    else if (l_access_fault | s_access_fault)  exc_tval = bad_addr;
    else                                       exc_tval = '0;
  end

  // Exceptions, mret and wfi only come from RUN; in FLUSH they belong to
  // squashed instructions. WAIT only reacts to interrupts.
  assign in_run    = (state_q == ST_RUN);
  assign in_wait   = (state_q == ST_WAIT);
  assign intr_ok   = mstatus_mie_q & inst_valid & pend_any;
  assign take_exc  = in_run & exc_any;
  assign take_intr = (in_run | in_wait) & ~take_exc & intr_ok;
  assign take_trap = take_exc | take_intr;
  assign take_mret = in_run & ~take_trap & mret;
  assign go_wait   = in_run & ~take_trap & ~take_mret & wfi;
  assign wake      = in_wait & pend_any;   // wake-up ignores mstatus.MIE
  assign csr_commit = in_run & csr_rw_in & (csr_wsc_mode_in != 2'b00)
                    & ~take_trap & ~take_mret;

  // CSR read mux (old value)
  always_comb begin
    rdata = '0;
    case (csr_rw_addr_in)
      A_MSTATUS: begin
        rdata[3] = mstatus_mie_q;
        rdata[7] = mstatus_mpie_q;
      end
      A_MIE:      rdata = mie_q;
      A_MTVEC:    rdata = mtvec_q;
      A_MSCRATCH: rdata = mscratch_q;
      A_MEPC:     rdata = {mepc_q, 2'b00};
      A_MCAUSE:   rdata = mcause_q;
      A_MTVAL:    rdata = mtval_q;
      A_MIP:      rdata = mip_w;
      default:    rdata = '0;
    endcase
  end

  assign csr_r_data_out = rdata;

  always_comb begin
    case (csr_wsc_mode_in)
      2'b01:   wval = csr_wdata_in;
      2'b10:   wval = rdata | csr_wdata_in;
      2'b11:   wval = rdata & ~csr_wdata_in;
      default: wval = rdata;
    endcase
  end

  // Redirect target; vectoring applies to interrupts only.
  assign mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};

  always_comb begin
    if (take_mret)
      target = {mepc_q, 2'b00};
    else if (take_intr && VECTORED && (mtvec_q[1:0] == 2'b01))
      target = mtvec_base + (XLEN'(irq_code) << 2);
    else
      target = mtvec_base;
  end

  // Next-state
  always_comb begin
    state_d        = state_q;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;

    if (csr_commit) begin
      case (csr_rw_addr_in)
        A_MSTATUS: begin
          mstatus_mie_d  = wval[3];
          mstatus_mpie_d = wval[7];
        end
        A_MIE:      mie_d      = wval & MIE_MASK;
        A_MTVEC:    mtvec_d    = wval;
        A_MSCRATCH: mscratch_d = wval;
        A_MEPC:     mepc_d     = wval[XLEN-1:2];
        A_MCAUSE:   mcause_d   = wval;
        A_MTVAL:    mtval_d    = wval;
        default: ;
      endcase
    end

    if (take_trap) begin
      if (take_exc) begin
        mepc_d   = epc_cur[XLEN-1:2];
        mcause_d = exc_cause;
        mtval_d  = exc_tval;
      end else begin
        mepc_d   = epc_next[XLEN-1:2];
        mcause_d = {1'b1, {(XLEN-6){1'b0}}, irq_code};
        mtval_d  = '0;
      end
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (take_mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        if (take_trap | take_mret) state_d = ST_FLUSH;
        else if (go_wait)          state_d = ST_WAIT;
      end
      ST_FLUSH: state_d = ST_RUN;
      ST_WAIT: begin
        if (take_intr) state_d = ST_FLUSH;
        else if (wake) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    redirect_d    = take_trap | take_mret;
    pc_redirect_d = (take_trap | take_mret) ? target : '0;
    flush_d       = take_trap | take_mret;
    flush_mw_d    = take_exc;   // an interrupted instruction still retires
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RST;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      redirect_q     <= 1'b0;
      pc_redirect_q  <= '0;
      flush_q        <= 1'b0;
      flush_mw_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      redirect_q     <= redirect_d;
      pc_redirect_q  <= pc_redirect_d;
      flush_q        <= flush_d;
      flush_mw_q     <= flush_mw_d;
    end
  end

  assign PC_redirect     = pc_redirect_q;
  assign redirect_mux    = redirect_q;
  assign reg_FD_flush    = flush_q;
  assign reg_DE_flush    = flush_q;
  assign reg_EM_flush    = flush_q;
  assign reg_MW_flush    = flush_mw_q;
  // Combinational outputs are forced low while reset is asserted.
  assign RegWrite_cancel = ~rst & take_exc;
  assign stall_wfi       = ~rst & in_wait & ~pend_any;
  assign dbg_state_out   = state_q;

endmodule
